boot_mem_arbiter: RTL and testbench
===================================

Name: boot_mem_arbiter

Overview:
- Owns the single memory port in front of the multicycle core.
- After reset, it holds the core idle and runs a UART bootloader. The loader takes a little-endian word count followed by program words from the UART receiver and writes each word to memory at consecutive addresses.
- When loading completes, it hands the memory port to the core permanently and raises core_run.
- Sits between the core's adr/writedata/memwrite outputs and the memory.

Parameters:
- BOOT_BASE, 32'h0000_0000, byte address of the first loaded word.
- CNT_W, 16, width of the word counter; only length bits [CNT_W-1:0] are used.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
- rx_data  in  8  received byte
- core_adr  in  32  core memory address
- core_writedata  in  32  core store data
- core_memwrite  in  1  core store strobe
- mem_adr  out  32  address to memory
- mem_writedata  out  32  store data to memory
- mem_memwrite  out  1  store strobe to memory
- core_run  out  1  high = core may execute; low = core held stalled
- boot_err  out  1  sticky load error (see Optional Feature)

Behaviour:
- Interface: one clock (clk); reset rstn is asynchronous, active-low.
- Reset values:
  - state=S_LEN; byte index bidx=0; word index widx=0; length len=0.
  - Shift register sbuf=0; write register wreg=0.
  - core_run=0, boot_err=0, mem_memwrite=0.
- States: S_LEN, S_DATA, S_WRITE, S_RUN (and S_SUM, S_ERR when the optional feature is compiled in).
- Byte assembly: on rx_valid, sbuf[8*bidx +: 8] <= rx_data and bidx <= bidx+1 (2-bit, wraps 3->0). First received byte is the LSB.
- S_LEN: on the 4th byte, len <= {rx_data, sbuf[23:0]}[CNT_W-1:0].
  - If that value is 0, go to S_RUN; else go to S_DATA.
  - Upper length bits beyond CNT_W are discarded silently.
- S_DATA: on the 4th byte, wreg <= {rx_data, sbuf[23:0]} and go to S_WRITE.
- S_WRITE: exactly one cycle.
  - mem_memwrite=1, mem_adr=BOOT_BASE+{widx,2'b00}, mem_writedata=wreg.
  - At the end of the cycle, widx <= widx+1.
  - If widx+1==len, go to S_RUN (or S_SUM); else return to S_DATA.
  - An rx_valid arriving during S_WRITE is captured normally into sbuf (byte 0 of the next word); no byte is lost.
- S_RUN: the memory port is a pure combinational pass-through of core_adr/core_writedata/core_memwrite. core_run=1 from the first S_RUN cycle. rx_valid is ignored.
- Outside S_RUN:
  - mem_memwrite=0 except in S_WRITE.
  - mem_adr = loader address; mem_writedata = wreg.
  - core_* inputs are ignored.
- Latency: first cycle of mem_memwrite=1 is the cycle after the rx_valid carrying a word's 4th byte.
- widx wrap: len == 2^CNT_W is impossible because len is truncated; widx never exceeds len-1.
- Reset mid-load: all state returns to reset values immediately (asynchronous). Memory contents already written are not cleared. Loading restarts from the length header.
- core_run never falls except on reset.

Optional Feature:
- Macro: BOOT_CHECKSUM_EN.
- Defined:
  - After the last data word, the FSM enters S_SUM and receives a 4-byte little-endian trailer.
  - The trailer is compared with the mod-2^32 sum of all written words, accumulated in S_WRITE.
  - Equal: go to S_RUN.
  - Different: go to S_ERR, where boot_err=1 (sticky), core_run=0 and rx_valid is ignored until reset.
  - With len==0, S_LEN goes to S_SUM and the expected sum is 0.
- Undefined: no trailer, no S_SUM/S_ERR, and boot_err is tied 0.

Test Plan:
- Send bytes 02 00 00 00, then 13 00 00 00, then 93 00 10 00 (BOOT_BASE=0):
  - Writes 32'h00000013 at adr 0, then 32'h00100093 at adr 4.
  - Each write is a single-cycle mem_memwrite.
  - core_run rises the cycle after the second write.
- Send 00 00 00 00: core_run=1 with no memory write. Afterwards core_memwrite=1 with core_adr=32'h100 appears on the mem_* ports in the same cycle.
- Back-to-back rx_valid, with the 1st byte of word 2 arriving in the S_WRITE cycle of word 1: both words are written intact.
- Length bytes 03 00 01 00 with CNT_W=16: len=3, and exactly 3 words are written.
- Deassert rstn after 6 data bytes: outputs return to reset values at once. A fresh 1-word load afterwards writes adr 0.
- With BOOT_CHECKSUM_EN:
  - Words 1 and 2 with trailer 03 00 00 00: core_run=1.
  - Same words with trailer 04 00 00 00: boot_err=1, core_run stays 0, and further bytes are ignored.

Source files
------------

// File: rtl/boot_mem_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// boot_mem_arbiter
//
// Owns the single memory port in front of the multicycle core. Out of reset the
// core is held stalled while a UART bootloader receives a little-endian 32-bit
// word count followed by that many little-endian program words. Each word is
// written to memory at consecutive word addresses starting at BOOT_BASE. Once
// the last word is written, the memory port is handed to the core for good and
// core_run is raised.
//
// Optional feature (macro BOOT_CHECKSUM_EN): after the last data word a 4-byte
// little-endian trailer is received and compared with the mod-2^32 sum of all
// written words. A match releases the core. A mismatch parks the loader in an
// error state with boot_err set until reset. Without the macro, there is no
// trailer and boot_err is tied low.
//
// Parameters
//   BOOT_BASE      byte address of the first loaded word
//   CNT_W          width of the word counter (length bits [CNT_W-1:0] used)
// Ports
//   clk            system clock
//   rstn           asynchronous active-low reset
//   rx_valid       one-cycle strobe, rx_data holds a received byte
//   rx_data        received byte
//   core_adr       core memory address
//   core_writedata core store data
//   core_memwrite  core store strobe
//   mem_adr        address to memory
//   mem_writedata  store data to memory
//   mem_memwrite   store strobe to memory
//   core_run       high = core may execute, low = core held stalled
//   boot_err       sticky checksum error (always 0 without BOOT_CHECKSUM_EN)
// -----------------------------------------------------------------------------
module boot_mem_arbiter #(
   parameter logic [31:0] BOOT_BASE = 32'h0000_0000,
   parameter int          CNT_W     = 16
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   input  logic [31:0] core_adr,
   input  logic [31:0] core_writedata,
   input  logic        core_memwrite,
   output logic [31:0] mem_adr,
   output logic [31:0] mem_writedata,
   output logic        mem_memwrite,
   output logic        core_run,
   output logic        boot_err
);

   typedef enum logic [2:0] {
      S_LEN   = 3'd0,
      S_DATA  = 3'd1,
      S_WRITE = 3'd2,
      S_RUN   = 3'd3
`ifdef BOOT_CHECKSUM_EN
      ,
      S_SUM   = 3'd4,
      S_ERR   = 3'd5
`endif
   } state_t;

   // State entered once every data word has been written (or when len is 0).
`ifdef BOOT_CHECKSUM_EN
   localparam state_t S_DONE = S_SUM;
`else
   localparam state_t S_DONE = S_RUN;
`endif

   state_t           state_reg, state_next;
   logic [1:0]       bidx_reg;
   logic [CNT_W-1:0] widx_reg;
   logic [CNT_W-1:0] len_reg;
   // Only bytes 0..2 need storing: byte 3 is consumed straight from rx_data
   // in the same cycle that completes the word.
   logic [23:0]      sbuf_reg;
   logic [31:0]      wreg_reg;
`ifdef BOOT_CHECKSUM_EN
   logic [31:0]      sum_reg;
`endif

   logic [31:0]      rx_word;
   logic             last_byte;
   logic             accept;
   logic [CNT_W-1:0] len_value;
   logic [CNT_W-1:0] widx_inc;
   logic             last_word;
   logic [31:0]      loader_adr;

   assign rx_word    = {rx_data, sbuf_reg};
   assign len_value  = rx_word[CNT_W-1:0];
   // widx never exceeds len-1, so the increment cannot wrap.
   assign widx_inc   = widx_reg + CNT_W'(1);
   assign last_word  = (widx_inc == len_reg);
   assign loader_adr = BOOT_BASE + 32'({widx_reg, 2'b00});

   // Bytes are collected in every loading state, including the single
   // S_WRITE cycle, so a byte arriving back-to-back is never dropped.
   always_comb begin
      accept = 1'b0;
      case (state_reg)
         S_LEN, S_DATA, S_WRITE: accept = rx_valid;
`ifdef BOOT_CHECKSUM_EN
         S_SUM:                  accept = rx_valid;
`endif
         default:                accept = 1'b0;
      endcase
   end

   assign last_byte = accept && (bidx_reg == 2'd3);

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg <= S_LEN;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next state and memory-port multiplexing
   always_comb begin
      state_next    = state_reg;
      mem_adr       = loader_adr;
      mem_writedata = wreg_reg;
      mem_memwrite  = 1'b0;
      core_run      = 1'b0;
      boot_err      = 1'b0;
      case (state_reg)
         S_LEN: begin
            if (last_byte) begin
               state_next = (len_value == '0) ? S_DONE : S_DATA;
            end
         end
         S_DATA: begin
            if (last_byte) begin
               state_next = S_WRITE;
            end
         end
         S_WRITE: begin
            mem_memwrite = 1'b1;
            state_next   = last_word ? S_DONE : S_DATA;
         end
         S_RUN: begin
            mem_adr       = core_adr;
            mem_writedata = core_writedata;
            mem_memwrite  = core_memwrite;
            core_run      = 1'b1;
         end
`ifdef BOOT_CHECKSUM_EN
         S_SUM: begin
            if (last_byte) begin
               state_next = (rx_word == sum_reg) ? S_RUN : S_ERR;
            end
         end
         S_ERR: begin
            boot_err = 1'b1;
         end
`endif
         default: begin
            state_next = S_LEN;
         end
      endcase
   end

   // Loader datapath
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bidx_reg <= 2'd0;
         widx_reg <= '0;
         len_reg  <= '0;
         sbuf_reg <= '0;
         wreg_reg <= '0;
`ifdef BOOT_CHECKSUM_EN
         sum_reg  <= '0;
`endif
      end else begin
         if (accept) begin
            bidx_reg <= bidx_reg + 2'd1;
            if (bidx_reg != 2'd3) begin
               sbuf_reg[8*bidx_reg +: 8] <= rx_data;
            end
         end
         if (state_reg == S_LEN && last_byte) begin
            len_reg <= len_value;
         end
         if (state_reg == S_DATA && last_byte) begin
            wreg_reg <= rx_word;
         end
         if (state_reg == S_WRITE) begin
            widx_reg <= widx_inc;
`ifdef BOOT_CHECKSUM_EN
            sum_reg  <= sum_reg + wreg_reg;
`endif
         end
      end
   end

endmodule

// File: tb/tb_boot_mem_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_boot_mem_arbiter
//
// Self-checking bench for boot_mem_arbiter. Each load is described as a length
// header plus a word list. The expected memory writes are derived directly from
// that list: word i goes to BASE + 4*i, for the first len[15:0] words. In the
// checksum build, the expected trailer is the plain sum of the words. A monitor
// records every loader write while the core is stalled.
// -----------------------------------------------------------------------------
module tb_boot_mem_arbiter;

   localparam logic [31:0] BASE = 32'h0000_0000;
   localparam int          CW   = 16;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic [31:0] core_adr = 32'h0;
   logic [31:0] core_writedata = 32'h0;
   logic        core_memwrite = 1'b0;
   logic [31:0] mem_adr;
   logic [31:0] mem_writedata;
   logic        mem_memwrite;
   logic        core_run;
   logic        boot_err;

   boot_mem_arbiter #(.BOOT_BASE(BASE), .CNT_W(CW)) dut (
      .clk           (clk),
      .rstn          (rstn),
      .rx_valid      (rx_valid),
      .rx_data       (rx_data),
      .core_adr      (core_adr),
      .core_writedata(core_writedata),
      .core_memwrite (core_memwrite),
      .mem_adr       (mem_adr),
      .mem_writedata (mem_writedata),
      .mem_memwrite  (mem_memwrite),
      .core_run      (core_run),
      .boot_err      (boot_err)
   );

   always #5 clk = ~clk;

   int asserts  = 0;
   int failures = 0;
   int cyc      = 0;

   always @(posedge clk) cyc++;

   // Write monitor: loader writes only (core stalled).
   logic [31:0] wa_q[$];
   logic [31:0] wd_q[$];
   int          wc_q[$];
   int          run_cyc = -1;

   always @(negedge clk) begin
      if (mem_memwrite && !core_run) begin
         wa_q.push_back(mem_adr);
         wd_q.push_back(mem_writedata);
         wc_q.push_back(cyc);
      end
      if (core_run && run_cyc < 0) run_cyc = cyc;
   end

   logic [31:0] pay_q[$];

   task automatic clear_mon;
      wa_q.delete();
      wd_q.delete();
      wc_q.delete();
      run_cyc = -1;
   endtask

   task automatic do_reset;
      rstn     = 1'b0;
      rx_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      clear_mon();
      @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; leaves at posedge+1.
   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_valid       = 1'b1;
      rx_data        = b;
      // Core-side inputs must be ignored while loading.
      core_adr       = $urandom;
      core_writedata = $urandom;
      core_memwrite  = 1'($urandom);
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_word(input logic [31:0] w, input int maxgap);
      for (int i = 0; i < 4; i++) begin
         send_byte(w[8*i +: 8], int'($urandom_range(maxgap, 0)));
      end
   endtask

   // Sends header, pay_q words and (checksum build) trailer, then checks the
   // writes seen against the model. trailer_xor != 0 corrupts the trailer.
   task automatic run_load(input string name, input logic [31:0] len_field,
                           input int maxgap, input logic [31:0] trailer_xor);
      int          n;
      logic [31:0] exp_sum;
      logic        expect_ok;
      n       = int'(len_field[CW-1:0]);
      exp_sum = 32'h0;
      for (int i = 0; i < n; i++) exp_sum = exp_sum + pay_q[i];
`ifdef BOOT_CHECKSUM_EN
      expect_ok = (trailer_xor == 32'h0);
`else
      expect_ok = 1'b1;
`endif
      clear_mon();
      send_word(len_field, maxgap);
      for (int i = 0; i < n; i++) send_word(pay_q[i], maxgap);
`ifdef BOOT_CHECKSUM_EN
      send_word(exp_sum ^ trailer_xor, maxgap);
`endif
      if (expect_ok) begin
         for (int i = 0; i < 20 && run_cyc < 0; i++) @(posedge clk);
      end else begin
         repeat (10) @(posedge clk);
      end
      #1;
      core_memwrite = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      $display("load %s: len_field=%08h words=%0d writes_seen=%0d core_run=%0b boot_err=%0b",
               name, len_field, n, wa_q.size(), core_run, boot_err);

      asserts++;
      if (wa_q.size() !== n) begin
         failures++;
         $display("FAIL %s write_count: got %0d expected %0d", name, wa_q.size(), n);
      end
      for (int i = 0; i < n && i < wa_q.size(); i++) begin
         asserts++;
         if (wa_q[i] !== BASE + 32'(4 * i) || wd_q[i] !== pay_q[i]) begin
            failures++;
            $display("FAIL %s write[%0d]: got adr=%08h data=%08h expected adr=%08h data=%08h",
                     name, i, wa_q[i], wd_q[i], BASE + 32'(4 * i), pay_q[i]);
         end
      end
      asserts++;
      if (core_run !== expect_ok) begin
         failures++;
         $display("FAIL %s core_run: got %0b expected %0b", name, core_run, expect_ok);
      end
      asserts++;
      if (boot_err !== !expect_ok) begin
         failures++;
         $display("FAIL %s boot_err: got %0b expected %0b", name, boot_err, !expect_ok);
      end
`ifndef BOOT_CHECKSUM_EN
      if (n > 0 && wc_q.size() == n) begin
         asserts++;
         if (run_cyc !== wc_q[n-1] + 1) begin
            failures++;
            $display("FAIL %s run_timing: core_run rose at cycle %0d expected %0d",
                     name, run_cyc, wc_q[n-1] + 1);
         end
      end
`endif
   endtask

   task automatic test_reset;
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      asserts++;
      if (core_run !== 1'b0 || boot_err !== 1'b0 || mem_memwrite !== 1'b0) begin
         failures++;
         $display("FAIL reset_flags: got run=%0b err=%0b we=%0b expected 0 0 0",
                  core_run, boot_err, mem_memwrite);
      end
      asserts++;
      if (mem_adr !== BASE || mem_writedata !== 32'h0) begin
         failures++;
         $display("FAIL reset_port: got adr=%08h data=%08h expected %08h 00000000",
                  mem_adr, mem_writedata, BASE);
      end
      do_reset();
      asserts++;
      if (core_run !== 1'b0) begin
         failures++;
         $display("FAIL reset_stall: got core_run=%0b expected 0", core_run);
      end
   endtask

   task automatic test_example;
      do_reset();
      pay_q = '{32'h0000_0013, 32'h0010_0093};
      run_load("example", 32'h0000_0002, 2, 32'h0);
   endtask

   task automatic test_zero_len;
      logic [31:0] d;
      do_reset();
      pay_q.delete();
      run_load("zero_len", 32'h0000_0000, 1, 32'h0);
      d              = $urandom;
      core_adr       = 32'h0000_0100;
      core_writedata = d;
      core_memwrite  = 1'b1;
      #1;
      asserts++;
      if (mem_adr !== 32'h100 || mem_writedata !== d || mem_memwrite !== 1'b1) begin
         failures++;
         $display("FAIL passthrough: got adr=%08h data=%08h we=%0b expected 00000100 %08h 1",
                  mem_adr, mem_writedata, mem_memwrite, d);
      end
      core_memwrite = 1'b0;
      #1;
      asserts++;
      if (mem_memwrite !== 1'b0) begin
         failures++;
         $display("FAIL passthrough_we_low: got %0b expected 0", mem_memwrite);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back;
      do_reset();
      pay_q.delete();
      for (int i = 0; i < 3; i++) pay_q.push_back($urandom);
      run_load("back_to_back", 32'h0000_0003, 0, 32'h0);
   endtask

   task automatic test_len_trunc;
      do_reset();
      pay_q.delete();
      for (int i = 0; i < 3; i++) pay_q.push_back($urandom);
      run_load("len_trunc", 32'h0001_0003, 1, 32'h0);
   endtask

   task automatic test_random;
      int n;
      for (int it = 0; it < 6; it++) begin
         do_reset();
         n = int'($urandom_range(5, 1));
         pay_q.delete();
         for (int i = 0; i < n; i++) pay_q.push_back($urandom);
         run_load("random", {16'($urandom), 16'(n)}, 3, 32'h0);
      end
   endtask

   task automatic test_reset_mid_load;
      do_reset();
      clear_mon();
      send_word(32'h0000_0002, 1);
      send_word(32'hCAFE_F00D, 1);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      core_memwrite = 1'b0;
      asserts++;
      if (wa_q.size() !== 1) begin
         failures++;
         $display("FAIL midload_first_write: got %0d writes expected 1", wa_q.size());
      end
      rstn = 1'b0;
      #1;
      asserts++;
      if (core_run !== 1'b0 || mem_memwrite !== 1'b0 || mem_adr !== BASE ||
          mem_writedata !== 32'h0 || boot_err !== 1'b0) begin
         failures++;
         $display("FAIL midload_async_reset: got run=%0b we=%0b adr=%08h data=%08h err=%0b expected 0 0 %08h 00000000 0",
                  core_run, mem_memwrite, mem_adr, mem_writedata, boot_err, BASE);
      end
      @(posedge clk);
      #1 rstn = 1'b1;
      @(posedge clk);
      #1;
      pay_q = '{32'h1234_5678};
      run_load("after_reset", 32'h0000_0001, 1, 32'h0);
   endtask

`ifdef BOOT_CHECKSUM_EN
   task automatic test_checksum;
      do_reset();
      pay_q = '{32'h0000_0001, 32'h0000_0002};
      run_load("sum_good", 32'h0000_0002, 1, 32'h0);
      do_reset();
      pay_q = '{32'h0000_0001, 32'h0000_0002};
      // 3 ^ 7 = 4: trailer 04 00 00 00
      run_load("sum_bad", 32'h0000_0002, 1, 32'h0000_0007);
      clear_mon();
      send_word(32'h0000_0001, 0);
      send_word(32'hDEAD_BEEF, 0);
      core_memwrite = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      asserts++;
      if (wa_q.size() !== 0 || boot_err !== 1'b1 || core_run !== 1'b0) begin
         failures++;
         $display("FAIL sum_err_sticky: got writes=%0d err=%0b run=%0b expected 0 1 0",
                  wa_q.size(), boot_err, core_run);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_example();
      test_zero_len();
      test_back_to_back();
      test_len_trunc();
      test_random();
      test_reset_mid_load();
`ifdef BOOT_CHECKSUM_EN
      test_checksum();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
      $finish;
   end

endmodule
